reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//  Round-robin write arbiter for one shared WIDTH-bit register built from enabled D flip-flops.
//  Up to N_REQ requesters compete for the register. The block grants one requester at a time.
//  It drives the register's enable (reg_e) and data (reg_d), so at most one write lands per cycle.
//  It sits between the requesting datapath blocks and the register bank's e/data_in pins.
// PARAMETERS
//  N_REQ     4  number of requesters (2..8)
//  WIDTH     8  data width of shared register
//  MAX_HOLD  4  max consecutive write cycles a locked requester may keep the grant (>=1)
// PORTS
//  clk        in   1              system clock, rising edge
//  rst        in   1              synchronous, active-high reset
//  req        in   N_REQ          per-requester write request, held until gnt seen
//  lock       in   N_REQ          per-requester burst lock, meaningful only while granted
//  wdata      in   N_REQ*WIDTH    requester i data at [i*WIDTH +: WIDTH]
//  gnt        out  N_REQ          one-hot registered grant, all-zero when idle
//  reg_e      out  1              enable to shared register, high exactly when gnt != 0
//  reg_d      out  WIDTH          data to shared register, valid while reg_e
//  busy       out  1              high in GRANT or LOCK state
//  grant_cnt  out  16             total grants issued (only with ARB_GRANT_CNT_EN)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): gnt=0, reg_e=0, reg_d=0, busy=0, state=IDLE, rr pointer=0, hold count=0.
//    - Reset wins over every other event. An in-flight burst is abandoned; no write occurs in the cycle after reset.
//  - Latency: req sampled at edge k -> gnt/reg_e/reg_d valid in cycle k+1.
//    - reg_d = wdata of the winner as sampled at edge k (registered, no combinational path).
//  - Winner: the first asserted req scanning upward (with wrap) from the rr pointer.
//    - After each grant, the pointer moves to winner+1 mod N_REQ.
//  - FSM states: IDLE, GRANT, LOCK.
//    - IDLE: req==0 -> IDLE. Otherwise -> GRANT with the winner.
//    - GRANT (one write): if lock[g] && req[g] && MAX_HOLD>1 -> LOCK, hold count=1, same g.
//      Else, if another req pending -> GRANT with new winner (back-to-back, no bubble). Else -> IDLE.
//    - LOCK: each cycle is one further write with fresh wdata[g] and hold count +1.
//      Stay while lock[g] && req[g] && count<MAX_HOLD-1. Otherwise re-arbitrate as from GRANT.
//      Re-arbitration excludes g if other requesters are pending.
//  - Fairness: no requester is granted twice while another continuously-requesting requester waits.
//    A locked burst counts as one grant.
//  - A requester dropping req mid-burst ends the burst that edge. Its data is not written that cycle.
//  - Simultaneous req from all N_REQ: grants rotate from the pointer.
//  - The pointer wraps N_REQ-1 -> 0.
//  - lock on a non-granted requester is ignored.
//  - gnt is always one-hot or zero, and reg_e == |gnt in every cycle.
// CONFIGURATION
//  ARB_GRANT_CNT_EN defined:
//    - grant_cnt port exists.
//    - Increments on every entry to GRANT; LOCK cycles do not increment it.
//    - Wraps at 16'hFFFF -> 0. Reset to 0.
//  ARB_GRANT_CNT_EN undefined:
//    - Port and counter are absent.
//    - All other behaviour is identical.
// STRUCTURE
//  - Shared header reg-arb-defs.vh holds the state encodings localparams:
//    ST_IDLE=2'd0, ST_GRANT=2'd1, ST_LOCK=2'd2.
//  - It also holds the grant counter width (16). The bench includes the same header.
//  - One sub-module, rr_priority_picker (combinational): inputs req, ptr, exclude mask; outputs one-hot winner and valid.
//  - FSM, pointer, hold counter, output registers and optional counter live in reg_write_arbiter.
// TESTING
//  1. rst=1 for 2 cycles with random req: gnt=0, reg_e=0, reg_d=0, busy=0 throughout; grant_cnt=0.
//  2. Single request: req=4'b0100, wdata[2]=8'hA5 at edge k.
//     -> cycle k+1: gnt=4'b0100, reg_e=1, reg_d=8'hA5.
//     -> req dropped: cycle k+2 gnt=0, IDLE.
//  3. req=4'b1111 held, lock=0.
//     -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles, no bubbles.
//     -> grant_cnt=5 after 5 grants.
//  4. req=4'b0011, lock[0]=1, MAX_HOLD=4.
//     -> gnt=0001 for exactly 4 cycles, then 0010.
//     -> reg_d tracks wdata[0] each cycle.
//  5. Burst in LOCK (count=2) with rst=1 asserted.
//     -> next cycle gnt=0, reg_e=0.
//     -> after release with req=4'b0001: grant to 0 (pointer reset).
//  6. Locked requester 1 drops req mid-burst while req[3]=1.
//     -> next cycle gnt=1000. No extra write for requester 1.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg: state encodings, counter width and a small helper
// shared by the register write arbiter and anything that needs to agree with it.
package reg_write_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_LOCK  = 2'd2;

    localparam int GCNT_W = 16;

    // Next requester index after idx, wrapping back to 0 past the last one.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_priority_picker.sv
// rr_priority_picker: combinational round-robin picker. Scans upward from ptr
// (wrapping) and returns the first requester not masked by exclude, one-hot.
module rr_priority_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    input  logic [N_REQ-1:0] exclude,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    logic [N_REQ-1:0] eligible;

    assign eligible = req & ~exclude;

    // Walk the requesters starting at the pointer and keep only the first eligible one.
    always_comb begin : pick
        int idx;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!valid && eligible[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write arbiter for one shared register.
// Grants one requester at a time, optionally as a locked burst of up to
// MAX_HOLD writes, and drives the register's enable and data.
// Optional feature macro: ARB_GRANT_CNT_EN adds the grant_cnt output.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         lock,
    input  logic [N_REQ*WIDTH-1:0]   wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic                     reg_e,
    output logic [WIDTH-1:0]         reg_d,
    output logic                     busy
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [GCNT_W-1:0]        grant_cnt
`endif
);

    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [1:0]        state;
    logic [PTR_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic [N_REQ-1:0]  excl;
    logic [N_REQ-1:0]  win_oh;
    logic              win_valid;
    logic              lock_g;
    logic              req_g;
    logic              others_pending;
    logic              burst_go;
    logic [WIDTH-1:0]  next_d;
    int                cur_idx;
    int                win_idx;

    assign reg_e = |gnt;
    assign busy  = (state != ST_IDLE);

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req     (req),
        .ptr     (ptr),
        .exclude (excl),
        .winner  (win_oh),
        .valid   (win_valid)
    );

    // Index of the requester currently holding the grant.
    always_comb begin
        cur_idx = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                cur_idx = i;
            end
        end
    end

    // Index of the requester the picker chose for a fresh grant.
    always_comb begin
        win_idx = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx = i;
            end
        end
    end

    // Decide whether the current owner keeps the grant for another burst write,
    // and keep it out of re-arbitration while someone else is waiting.
    always_comb begin
        lock_g         = |(lock & gnt);
        req_g          = |(req & gnt);
        others_pending = |(req & ~gnt);
        excl           = others_pending ? gnt : '0;
        burst_go       = 1'b0;
        if (lock_g && req_g) begin
            if (state == ST_GRANT) begin
                burst_go = (MAX_HOLD > 1);
            end else if (state == ST_LOCK) begin
                burst_go = (int'(hold_cnt) < MAX_HOLD - 1);
            end
        end
    end

    assign next_d = burst_go ? wdata[cur_idx*WIDTH +: WIDTH] : wdata[win_idx*WIDTH +: WIDTH];

    // FSM, round-robin pointer, burst length and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            reg_d    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else if (burst_go) begin
            state    <= ST_LOCK;
            hold_cnt <= (state == ST_GRANT) ? HOLD_W'(1) : hold_cnt + HOLD_W'(1);
            reg_d    <= next_d;
        end else if (win_valid) begin
            state    <= ST_GRANT;
            gnt      <= win_oh;
            reg_d    <= next_d;
            ptr      <= PTR_W'(wrap_inc(win_idx, N_REQ));
            hold_cnt <= '0;
        end else begin
            state    <= ST_IDLE;
            gnt      <= '0;
            reg_d    <= '0;
            hold_cnt <= '0;
        end
    end

`ifdef ARB_GRANT_CNT_EN
    logic take_grant;

    assign take_grant = !burst_go && win_valid;

    // Count every fresh grant; burst continuation cycles are not new grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
        end else if (take_grant) begin
            grant_cnt <= grant_cnt + GCNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed scenarios plus randomized traffic, checked
// against a behavioural model of owner/burst/pointer kept in the bench.
// Build with ARB_GRANT_CNT_EN defined to also check grant_cnt.
module tb_reg_write_arbiter;
    import reg_write_arbiter_pkg::*;

    localparam int N_REQ    = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       lock;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic                   reg_e;
    logic [WIDTH-1:0]       reg_d;
    logic                   busy;
`ifdef ARB_GRANT_CNT_EN
    logic [GCNT_W-1:0]      grant_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    int                m_owner     = -1;
    int                m_writes    = 0;
    int                m_ptr       = 0;
    logic [WIDTH-1:0]  m_data      = '0;
    logic [GCNT_W-1:0] m_cnt       = '0;
    logic              m_rst_seen  = 1'b0;

    logic [N_REQ-1:0]  rot_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .N_REQ    (N_REQ),
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .lock  (lock),
        .wdata (wdata),
        .gnt   (gnt),
        .reg_e (reg_e),
        .reg_d (reg_d),
        .busy  (busy)
`ifdef ARB_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Reference: an owner keeps writing while it holds lock and req, up to
    // MAX_HOLD writes per burst; otherwise the first requester from the pointer
    // wins, skipping the previous owner when anyone else is waiting.
    task automatic modelStep();
        int others;
        int w;
        m_rst_seen = rst;
        if (rst) begin
            m_owner  = -1;
            m_writes = 0;
            m_ptr    = 0;
            m_cnt    = '0;
            m_data   = '0;
            return;
        end
        if (m_owner >= 0 && req[m_owner] && lock[m_owner] && m_writes < MAX_HOLD) begin
            m_writes++;
            m_data = wdata[m_owner*WIDTH +: WIDTH];
            return;
        end
        others = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && i != m_owner) others++;
        end
        w = -1;
        for (int k = 0; k < N_REQ; k++) begin
            int i;
            i = (m_ptr + k) % N_REQ;
            if (w < 0 && req[i] && !(i == m_owner && others > 0)) w = i;
        end
        if (w < 0) begin
            m_owner  = -1;
            m_writes = 0;
            m_data   = '0;
        end else begin
            m_owner  = w;
            m_writes = 1;
            m_ptr    = (w + 1) % N_REQ;
            m_cnt    = m_cnt + 1'b1;
            m_data   = wdata[w*WIDTH +: WIDTH];
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".gnt"},    32'(gnt),   (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        checkOutput({tag, ".reg_e"},  32'(reg_e), 32'(m_owner >= 0));
        checkOutput({tag, ".busy"},   32'(busy),  32'(m_owner >= 0));
        checkOutput({tag, ".onehot"}, 32'($onehot0(gnt)), 32'd1);
        if (m_owner >= 0 || m_rst_seen) begin
            checkOutput({tag, ".reg_d"}, 32'(reg_d), 32'(m_data));
        end
`ifdef ARB_GRANT_CNT_EN
        checkOutput({tag, ".grant_cnt"}, 32'(grant_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic applyStimulus(input logic r, input logic [N_REQ-1:0] rq, input logic [N_REQ-1:0] lk,
                                 input logic [N_REQ*WIDTH-1:0] wd, input string tag);
        @(negedge clk);
        rst   = r;
        req   = rq;
        lock  = lk;
        wdata = wd;
        @(posedge clk);
        modelStep();
        #1;
        checkAll(tag);
    endtask

    initial begin
        logic [N_REQ*WIDTH-1:0] wd;

        // Reset with random requests present.
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, N_REQ'($urandom), N_REQ'($urandom), $urandom, "reset");
            checkOutput("reset.gnt_zero", 32'(gnt), 32'd0);
        end

        // Single request from requester 2, then released.
        wd = $urandom;
        wd[2*WIDTH +: WIDTH] = 8'hA5;
        applyStimulus(1'b0, 4'b0100, 4'b0000, wd, "single");
        checkOutput("single.gnt_const", 32'(gnt), 32'h4);
        checkOutput("single.reg_d_const", 32'(reg_d), 32'hA5);
        applyStimulus(1'b0, 4'b0000, 4'b0000, $urandom, "single_idle");
        checkOutput("single_idle.gnt_const", 32'(gnt), 32'd0);

        // All requesting without lock: strict rotation from a fresh pointer.
        applyStimulus(1'b1, 4'b0000, 4'b0000, '0, "rst3");
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 4'b1111, 4'b0000, $urandom, "rotate");
            checkOutput("rotate.gnt_const", 32'(gnt), 32'(rot_exp[c]));
        end
`ifdef ARB_GRANT_CNT_EN
        checkOutput("rotate.grant_cnt_const", 32'(grant_cnt), 32'd5);
`endif

        // Locked burst by requester 0 is capped at MAX_HOLD writes.
        applyStimulus(1'b1, 4'b0000, 4'b0000, '0, "rst4");
        for (int c = 0; c < MAX_HOLD; c++) begin
            wd = $urandom;
            applyStimulus(1'b0, 4'b0011, 4'b0001, wd, "lock");
            checkOutput("lock.gnt_const", 32'(gnt), 32'h1);
            checkOutput("lock.reg_d_track", 32'(reg_d), 32'(wd[WIDTH-1:0]));
        end
        applyStimulus(1'b0, 4'b0011, 4'b0001, $urandom, "lock_end");
        checkOutput("lock_end.gnt_const", 32'(gnt), 32'h2);

        // Reset in the middle of a burst abandons it and clears the pointer.
        applyStimulus(1'b1, 4'b0000, 4'b0000, '0, "rst5");
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 4'b0001, 4'b0001, $urandom, "burst5");
        end
        applyStimulus(1'b1, 4'b0001, 4'b0001, $urandom, "burst_rst");
        checkOutput("burst_rst.gnt_const", 32'(gnt), 32'd0);
        checkOutput("burst_rst.reg_e_const", 32'(reg_e), 32'd0);
        applyStimulus(1'b0, 4'b0001, 4'b0000, $urandom, "after_rst");
        checkOutput("after_rst.gnt_const", 32'(gnt), 32'h1);

        // Locked requester 1 drops req mid-burst while requester 3 waits.
        applyStimulus(1'b1, 4'b0000, 4'b0000, '0, "rst6");
        applyStimulus(1'b0, 4'b0010, 4'b0010, $urandom, "drop_grant");
        applyStimulus(1'b0, 4'b1010, 4'b0010, $urandom, "drop_lock");
        checkOutput("drop_lock.gnt_const", 32'(gnt), 32'h2);
        applyStimulus(1'b0, 4'b1000, 4'b0010, $urandom, "drop");
        checkOutput("drop.gnt_const", 32'(gnt), 32'h8);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            logic r;
            logic [N_REQ-1:0] lk;
            r  = ($urandom_range(0, 49) == 0);
            lk = ($urandom_range(0, 1) == 1) ? N_REQ'($urandom) : '0;
            applyStimulus(r, N_REQ'($urandom), lk, $urandom, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
